// File: rtl/sram_dp_be_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_dp_be_if
//  Purpose  : Write/read request bus of the byte-enable dual-port SRAM.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_dp_be_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_nb = WIDTH / 8;

    logic                busy;
    logic                wr_en;
    logic [c_aw-1:0]     wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic [c_nb-1:0]     wr_be;
    logic                err_inj;
    logic                rd_en;
    logic [c_aw-1:0]     rd_addr;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_valid;
    logic                parity_err;

    modport master (
        input  busy, rd_data, rd_valid, parity_err,
        output wr_en, wr_addr, wr_data, wr_be, err_inj, rd_en, rd_addr
    );

    modport slave (
        output busy, rd_data, rd_valid, parity_err,
        input  wr_en, wr_addr, wr_data, wr_be, err_inj, rd_en, rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/sram_dp_be.sv
`default_nettype none
// ============================================================================
//  Module   : sram_dp_be
//  Purpose  : 1W/1R SRAM with byte enables, RD_LAT 1/2, collision policy and
//             a post-reset zero-fill sweep. Optional byte parity: SRAM_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sram_dp_be #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 1,
    parameter int COLL_MODE = 0
) (
    input  logic        clk,
    input  logic        rstn,
    sram_dp_be_if.slave bus
);
    localparam int              c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_nb    = WIDTH / 8;
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw-1:0] c_last  = c_aw'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_aw-1:0] r_init_addr;
    logic [c_aw-1:0] w_init_addr_nxt;
    logic            w_busy;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_inr;
    logic             w_rd_inr;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_rd_coll;
    logic [c_aw-1:0]  w_wr_idx;
    logic [c_aw-1:0]  w_rd_idx;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_wr_word;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_rd_perr;

    logic             w_mem_we;
    logic [c_aw-1:0]  w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;

    logic [WIDTH-1:0] r_rd_d1;
    logic             r_rd_v1;
    logic             r_rd_p1;

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= w_init_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_init_addr_nxt = r_init_addr;
        w_busy          = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy = 1'b1;
                if (r_init_addr == c_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_init_addr_nxt = r_init_addr + c_aw'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign bus.busy = w_busy;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_wr_inr  = ({1'b0, bus.wr_addr} < c_depth);
    assign w_rd_inr  = ({1'b0, bus.rd_addr} < c_depth);
    assign w_wr_acc  = !w_busy && bus.wr_en && w_wr_inr;
    assign w_rd_acc  = !w_busy && bus.rd_en;
    // Clamped indices keep array lookups inside bounds for dropped requests
    assign w_wr_idx  = w_wr_inr ? bus.wr_addr : '0;
    assign w_rd_idx  = w_rd_inr ? bus.rd_addr : '0;
    assign w_rd_coll = w_wr_acc && (bus.wr_addr == bus.rd_addr);

    assign w_wr_old  = r_mem[w_wr_idx];

    always_comb begin
        w_wr_word = w_wr_old;
        for (int i = 0; i < c_nb; i++) begin
            if (bus.wr_be[i]) begin
                w_wr_word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_inr) begin
            w_rd_word = ((COLL_MODE == 1) && w_rd_coll) ? w_wr_word : r_mem[w_rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Array write port, shared by the init sweep and user writes
    // ------------------------------------------------------------------
    assign w_mem_we    = w_busy || w_wr_acc;
    assign w_mem_addr  = w_busy ? r_init_addr : w_wr_idx;
    assign w_mem_wdata = w_busy ? '0 : w_wr_word;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [c_nb-1:0] r_par [DEPTH];
    logic [c_nb-1:0] w_wr_par;
    logic [c_nb-1:0] w_rd_par;
    logic [c_nb-1:0] w_rd_mis;

    // Even parity per byte; err_inj flips byte 0 only when that byte is written
    always_comb begin
        w_wr_par = r_par[w_wr_idx];
        for (int i = 0; i < c_nb; i++) begin
            if (bus.wr_be[i]) begin
                w_wr_par[i] = (^bus.wr_data[8*i +: 8]) ^ ((i == 0) ? bus.err_inj : 1'b0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_par[w_mem_addr] <= w_busy ? '0 : w_wr_par;
        end
    end

    always_comb begin
        w_rd_par = ((COLL_MODE == 1) && w_rd_coll) ? w_wr_par : r_par[w_rd_idx];
        w_rd_mis = '0;
        for (int i = 0; i < c_nb; i++) begin
            w_rd_mis[i] = (^w_rd_word[8*i +: 8]) ^ w_rd_par[i];
        end
        w_rd_perr = w_rd_inr && (|w_rd_mis);
    end
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = bus.err_inj;
    assign w_rd_perr        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read pipeline; data registers load only on valid so outputs hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_d1 <= '0;
            r_rd_v1 <= 1'b0;
            r_rd_p1 <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_d1 <= w_rd_word;
                r_rd_p1 <= w_rd_perr;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] r_rd_d2;
            logic             r_rd_v2;
            logic             r_rd_p2;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rd_d2 <= '0;
                    r_rd_v2 <= 1'b0;
                    r_rd_p2 <= 1'b0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_d2 <= r_rd_d1;
                        r_rd_p2 <= r_rd_p1;
                    end
                end
            end

            assign bus.rd_data    = r_rd_d2;
            assign bus.rd_valid   = r_rd_v2;
            assign bus.parity_err = r_rd_p2 && r_rd_v2;
        end else begin : g_lat1
            assign bus.rd_data    = r_rd_d1;
            assign bus.rd_valid   = r_rd_v1;
            assign bus.parity_err = r_rd_p1 && r_rd_v1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_be.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_dp_be
//  Purpose  : Two DUT flavours (RD_LAT=1/read-old, RD_LAT=2/write-through)
//             driven in lockstep and compared against an array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_dp_be;
    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int MAXS  = 8192;
`ifdef SRAM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sram_dp_be_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
    sram_dp_be_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

    sram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(1), .COLL_MODE(0)) u_dut0 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus0)
    );

    sram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(2), .COLL_MODE(1)) u_dut1 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus1)
    );

    // Reference state: word contents plus a "byte-0 parity poisoned" flag
    logic [31:0] mem  [DEPTH];
    bit          bad  [DEPTH];
    bit          rst_on    = 1'b1;
    int          since_rel = 0;
    int          step_n    = 0;
    bit          ev [2][MAXS];
    logic [31:0] ed [2][MAXS];
    bit          ep [2][MAXS];
    logic [31:0] last_d [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", tag, step_n, act, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic busy, input logic rv,
                             input logic pe, input logic [31:0] rd);
        bit exp_busy;
        bit exp_v;
        exp_busy = rst_on || (since_rel < DEPTH);
        exp_v    = ev[k][step_n];
        if (exp_v) last_d[k] = ed[k][step_n];
        check($sformatf("dut%0d.busy", k), 32'(busy), 32'(exp_busy));
        check($sformatf("dut%0d.rd_valid", k), 32'(rv), 32'(exp_v));
        check($sformatf("dut%0d.rd_data", k), rd, last_d[k]);
        check($sformatf("dut%0d.parity_err", k), 32'(pe), 32'(exp_v && ep[k][step_n]));
    endtask

    task automatic step(input bit rn, input bit we, input logic [AW-1:0] wa,
                        input logic [31:0] wd, input logic [NB-1:0] be, input bit inj,
                        input bit re, input logic [AW-1:0] ra);
        logic [31:0] old_d, new_d;
        bit          old_b, new_b;
        @(negedge clk);
        check_dut(0, bus0.busy, bus0.rd_valid, bus0.parity_err, bus0.rd_data);
        check_dut(1, bus1.busy, bus1.rd_valid, bus1.parity_err, bus1.rd_data);

        rstn = rn;
        bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.wr_be = be;
        bus0.err_inj = inj; bus0.rd_en = re; bus0.rd_addr = ra;
        bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd; bus1.wr_be = be;
        bus1.err_inj = inj; bus1.rd_en = re; bus1.rd_addr = ra;

        if (!rn) begin
            rst_on = 1'b1;
            for (int d = 1; d <= 2; d++) begin
                ev[0][step_n+d] = 1'b0;
                ev[1][step_n+d] = 1'b0;
            end
            last_d[0] = '0;
            last_d[1] = '0;
        end else if (rst_on) begin
            rst_on    = 1'b0;
            since_rel = 0;
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] = '0;
                bad[a] = 1'b0;
            end
        end

        if (!rst_on && since_rel >= DEPTH) begin
            old_d = '0; old_b = 1'b0;
            if (ra < DEPTH) begin old_d = mem[ra]; old_b = bad[ra]; end
            if (we && wa < DEPTH) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) mem[wa][8*i +: 8] = wd[8*i +: 8];
                if (be[0]) bad[wa] = inj;
            end
            new_d = '0; new_b = 1'b0;
            if (ra < DEPTH) begin new_d = mem[ra]; new_b = bad[ra]; end
            if (re) begin
                ev[0][step_n+1] = 1'b1; ed[0][step_n+1] = old_d; ep[0][step_n+1] = old_b & PAR_ON;
                ev[1][step_n+2] = 1'b1; ed[1][step_n+2] = new_d; ep[1][step_n+2] = new_b & PAR_ON;
            end
        end

        if (!rst_on) since_rel++;
        step_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        last_d[0] = '0;
        last_d[1] = '0;
        for (int s = 0; s < MAXS; s++) begin
            ev[0][s] = 1'b0; ev[1][s] = 1'b0;
            ed[0][s] = '0;   ed[1][s] = '0;
            ep[0][s] = 1'b0; ep[1][s] = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) begin mem[a] = '0; bad[a] = 1'b0; end

        hold_reset(3);
        // Requests during the sweep must be ignored
        for (int i = 0; i < DEPTH + 2; i++)
            step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom, 4'hF, 1'b0,
                 1'b1, AW'($urandom_range(0, DEPTH - 1)));
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, AW'(a));
        idle(3);

        step(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd5);
        idle(3);

        step(1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 4'd7);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd7);
        idle(3);

        for (int a = 1; a <= 3; a++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, AW'(a));
        idle(4);

        step(1'b1, 1'b1, 4'd12, 32'h12345678, 4'b1111, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd12);
        idle(3);

        step(1'b1, 1'b1, 4'd3, 32'h0F0F0F01, 4'b1111, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd3);
        step(1'b1, 1'b1, 4'd3, 32'h000000FE, 4'b0001, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd3);
        idle(3);

        // Reset mid-sweep must restart the full count
        hold_reset(2);
        idle(4);
        hold_reset(2);
        idle(DEPTH + 3);

        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
            step(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1, wa, $urandom,
                 NB'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, ra);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
